mul8_share_arbiter: RTL and testbench



---
 rtl/mul8_share_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mul8_share_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_share_arbiter.sv
// Shared 8x8 multiplier front end.
// mul8_wallace is a combinational Wallace-tree multiplier; one copy sits
// outside mul8_share_arbiter on mul_a/mul_b -> mul_out.
// mul8_share_arbiter grants one of NREQ requesters per cycle (round robin),
// registers the operands into the multiplier and registers the product
// behind it. Products leave on one tagged response port.
//
// Handshake (request and response ports alike): a beat moves on a rising
// edge only when valid and ready are both 1 in the cycle before that edge.
// A source holds its payload steady while valid=1 and ready=0. A requester
// may withdraw valid before it is granted.

module mul8_wallace (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [16:0] p
);

  // Column 17 only collects carries that are arithmetically zero for 8x8.
  localparam int NC = 18;
  localparam int MH = 16;

  logic [MH-1:0] col [NC];
  logic [MH-1:0] nxt [NC];
  int            ht  [NC];
  int            nht [NC];
  int            maxh;
  logic          x, y, z;
  logic [16:0]   row0, row1;

  // Partial products, then 3:2 / 2:2 column compression until every column
  // is at most two bits high, then one carry-propagate add.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      col[c] = '0;
      nxt[c] = '0;
      ht[c]  = 0;
      nht[c] = 0;
    end
    maxh = 0;
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    row0 = '0;
    row1 = '0;

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        col[i+j] = col[i+j] | (MH'(a[i] & b[j]) << ht[i+j]);
        ht[i+j]  = ht[i+j] + 1;
      end
    end

    for (int s = 0; s < 6; s++) begin
      maxh = 0;
      for (int c = 0; c < NC; c++) begin
        if (ht[c] > maxh) maxh = ht[c];
      end
      if (maxh > 2) begin
        for (int c = 0; c < NC; c++) begin
          nxt[c] = '0;
          nht[c] = 0;
        end
        for (int c = 0; c < NC - 1; c++) begin
          for (int k = 0; k < MH; k += 3) begin
            x = |(col[c] & (MH'(1) << k));
            y = |(col[c] & (MH'(1) << (k + 1)));
            z = |(col[c] & (MH'(1) << (k + 2)));
            if (k + 2 < ht[c]) begin
              // full adder: sum stays, carry moves up one column
              nxt[c]   = nxt[c] | (MH'(x ^ y ^ z) << nht[c]);
              nht[c]   = nht[c] + 1;
              nxt[c+1] = nxt[c+1] | (MH'((x & y) | (x & z) | (y & z)) << nht[c+1]);
              nht[c+1] = nht[c+1] + 1;
            end else if (k + 1 < ht[c]) begin
              // half adder on a leftover pair
              nxt[c]   = nxt[c] | (MH'(x ^ y) << nht[c]);
              nht[c]   = nht[c] + 1;
              nxt[c+1] = nxt[c+1] | (MH'(x & y) << nht[c+1]);
              nht[c+1] = nht[c+1] + 1;
            end else if (k < ht[c]) begin
              nxt[c] = nxt[c] | (MH'(x) << nht[c]);
              nht[c] = nht[c] + 1;
            end
          end
        end
        for (int c = 0; c < NC; c++) begin
          col[c] = nxt[c];
          ht[c]  = nht[c];
        end
      end
    end

    for (int c = 0; c < 17; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
    p = row0 + row1;
  end

endmodule

module mul8_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [16:0]       mul_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_prod,
  output logic              ovf_err,
  output logic [15:0]       issue_cnt
);

  // Stage 1: operands feeding the multiplier
  logic           op_valid;
  logic [7:0]     op_a;
  logic [7:0]     op_b;
  logic [IDW-1:0] op_id;

  // Round-robin pointer: index searched first on the next arbitration
  logic [IDW-1:0] rr_ptr;

  logic           adv1;
  logic           adv2;
  logic           xfer;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand;
  logic [7:0]     win_a;
  logic [7:0]     win_b;

  // Stage 2 can take new data when empty or being drained this cycle;
  // stage 1 can take new data when empty or moving up into stage 2.
  assign adv2 = !rsp_valid || rsp_ready;
  assign adv1 = !op_valid || adv2;
  assign xfer = win_found && adv1 && !rst;

  assign mul_a = op_a;
  assign mul_b = op_b;

  // Winner: first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req_valid[i] && (cand == (IDW+1)'(i))) begin
          win_found = 1'b1;
          win_idx   = IDW'(i);
        end
      end
    end
  end

  // Operand select for the current winner
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_a = req_a[8*i +: 8];
        win_b = req_b[8*i +: 8];
      end
    end
  end

  // One-hot accept, only to the winner and only when stage 1 can load
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (win_idx == IDW'(i));
    end
  end

  // Stage 1 load from the winner; holds while stage 2 is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
    end else if (adv1) begin
      op_valid <= win_found;
      if (win_found) begin
        op_a  <= win_a;
        op_b  <= win_b;
        op_id <= win_idx;
      end
    end
  end

  // Stage 2 captures the multiplier result and the owner tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else if (adv2) begin
      rsp_valid <= op_valid;
      if (op_valid) begin
        rsp_prod <= mul_out[15:0];
        rsp_id   <= op_id;
      end
    end
  end

  // Sticky flag for a product wider than 16 bits arriving at stage 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (adv2 && op_valid && mul_out[16]) begin
      ovf_err <= 1'b1;
    end
  end

  // Pointer moves past the winner and the issue counter steps on each accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      issue_cnt <= '0;
    end else if (xfer) begin
      rr_ptr    <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
      issue_cnt <= issue_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul8_share_arbiter.sv
// Bench for mul8_share_arbiter with the Wallace multiplier closing the loop.
// The reference model keeps the round-robin pointer, an issue count, and a
// queue of outstanding products tagged with the edge at which each was
// accepted. An entry is presented at the response port one edge after it
// was accepted, provided everything before it has already been consumed.

module tb_mul8_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [16:0]       mul_out;
  logic [16:0]       mul_p;
  logic              inj_ovf;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_prod;
  logic              ovf_err;
  logic [15:0]       issue_cnt;

  int          n_tests;
  int          n_fail;
  logic [23:0] exp_q[$];
  int          acc_q[$];
  int          ecnt;
  int          m_rr;
  logic [15:0] m_cnt;
  logic        m_ovf;
  logic [15:0] base;

  mul8_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .ovf_err   (ovf_err),
    .issue_cnt (issue_cnt)
  );

  mul8_wallace u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  assign mul_out = {mul_p[16] | inj_ovf, mul_p[15:0]};

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'($urandom_range(0, 255));
      req_b[8*i +: 8] = 8'($urandom_range(0, 255));
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit              vis;
    bit              s1occ;
    bit              adv2m;
    bit              adv1m;
    bit              cap_ovf;
    int              win;
    int              t;
    logic [NREQ-1:0] expr;
    logic [7:0]      oa;
    logic [7:0]      ob;
    logic [15:0]     p;
    @(negedge clk);
    vis   = (exp_q.size() > 0) && (acc_q[0] < ecnt);
    s1occ = (exp_q.size() - (vis ? 1 : 0)) > 0;
    adv2m = !vis || rsp_ready;
    adv1m = !s1occ || adv2m;
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      t = (m_rr + k) % NREQ;
      if (win < 0 && req_valid[t]) win = t;
    end
    expr = '0;
    if (win >= 0 && adv1m && !rst) expr[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(expr));
    chk("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis) begin
      chk("rsp_id", 32'(rsp_id), 32'(exp_q[0][23:16]));
      chk("rsp_prod", 32'(rsp_prod), 32'(exp_q[0][15:0]));
    end
    chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    cap_ovf = s1occ && adv2m && inj_ovf;
    oa = 8'd0;
    ob = 8'd0;
    if (win >= 0) begin
      oa = req_a[8*win +: 8];
      ob = req_b[8*win +: 8];
    end
    @(posedge clk);
    ecnt++;
    if (vis && rsp_ready) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
    end
    if (expr != '0) begin
      p = 16'(oa) * 16'(ob);
      exp_q.push_back({8'(win), p});
      acc_q.push_back(ecnt);
      m_rr  = (win + 1) % NREQ;
      m_cnt = m_cnt + 16'd1;
    end
    if (cap_ovf) m_ovf = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) cycle();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ecnt      = 0;
    m_rr      = 0;
    m_cnt     = '0;
    m_ovf     = 1'b0;
    base      = '0;
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    inj_ovf   = 1'b0;

    // reset state, with requests pending so req_ready must still be zero
    #1 rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req_valid = '0;

    // single request 13*11, two edges to the response
    req_valid     = 4'b0001;
    req_a[7:0]    = 8'd13;
    req_b[7:0]    = 8'd11;
    cycle();
    req_valid = '0;
    chk("t1_early", 32'(rsp_valid), 32'd0);
    chk("t1_cnt", 32'(issue_cnt), 32'd1);
    cycle();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_id", 32'(rsp_id), 32'd0);
    chk("t1_prod", 32'(rsp_prod), 32'd143);
    idle(2);

    // all four valid; the pointer sits at 1 after the single request
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      #1 chk("t2_grant", 32'(req_ready), 32'(4'b0001 << ((1 + k) % 4)));
      cycle();
    end
    idle(3);

    // operand extremes through requester 2
    begin
      logic [7:0] ea [3];
      logic [7:0] eb [3];
      ea[0] = 8'd255; eb[0] = 8'd255;
      ea[1] = 8'd0;   eb[1] = 8'd200;
      ea[2] = 8'd1;   eb[2] = 8'd255;
      req_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
        req_a[23:16] = ea[k];
        req_b[23:16] = eb[k];
        cycle();
        if (k == 1) chk("t3_max", 32'(rsp_prod), 32'h0000FE01);
        if (k == 2) chk("t3_zero", 32'(rsp_prod), 32'd0);
      end
      req_valid = '0;
      cycle();
      chk("t3_one", 32'(rsp_prod), 32'd255);
      chk("t3_ovf", 32'(ovf_err), 32'd0);
      idle(2);
    end

    // backpressure: six requests, response side stalled for five cycles
    base = m_cnt;
    for (int k = 0; k < 40; k++) begin
      if (16'(m_cnt - base) < 16'd6) begin
        req_valid = 4'($urandom_range(1, 15));
        rand_ops();
      end else begin
        req_valid = '0;
      end
      rsp_ready = !(k >= 2 && k < 7);
      if (k == 6) begin
        #1 chk("t4_stall_ready", 32'(req_ready), 32'd0);
      end
      cycle();
    end
    chk("t4_issued", 32'(issue_cnt), 32'(base + 16'd6));
    chk("t4_drained", 32'(rsp_valid), 32'd0);

    // random traffic with random response backpressure
    for (int k = 0; k < 300; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rsp_ready = 1'b1;
    idle(4);

    // overflow flag via an injected bit 16 at the stage-2 capture
    req_valid = 4'b0001;
    rand_ops();
    cycle();
    req_valid = '0;
    inj_ovf = 1'b1;
    cycle();
    inj_ovf = 1'b0;
    chk("t6_ovf_set", 32'(ovf_err), 32'd1);
    idle(3);
    chk("t6_ovf_sticky", 32'(ovf_err), 32'd1);

    // reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      rand_ops();
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    chk("t7_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t7_req_ready", 32'(req_ready), 32'd0);
    chk("t7_issue_cnt", 32'(issue_cnt), 32'd0);
    chk("t7_ovf", 32'(ovf_err), 32'd0);
    exp_q.delete();
    acc_q.delete();
    m_rr  = 0;
    m_cnt = '0;
    m_ovf = 1'b0;
    @(posedge clk);
    ecnt++;
    #1;
    chk("t7_hold_valid", 32'(rsp_valid), 32'd0);
    chk("t7_hold_ready", 32'(req_ready), 32'd0);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1100;
    rand_ops();
    #1 chk("t7_first_grant", 32'(req_ready), 32'b0100);
    cycle();
    idle(4);

    // one requester alone, granted every cycle, until the count reaches 0xFFFF
    req_valid = 4'b0010;
    for (int g = 0; g < 70000 && m_cnt != 16'hFFFF; g++) begin
      rand_ops();
      cycle();
    end
    chk("t8_cnt_max", 32'(issue_cnt), 32'h0000FFFF);

    // sparse requests from pointer 2: grants 3, 1, 3 and the count wraps
    req_valid = 4'b1010;
    rand_ops();
    #1 chk("t9_grant3a", 32'(req_ready), 32'b1000);
    cycle();
    chk("t9_cnt_wrap", 32'(issue_cnt), 32'd0);
    rand_ops();
    #1 chk("t9_grant1", 32'(req_ready), 32'b0010);
    cycle();
    rand_ops();
    #1 chk("t9_grant3b", 32'(req_ready), 32'b1000);
    cycle();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
